// File: rtl/rs_encode_stream_in_ctrl.sv
// rs_encode_stream_in_ctrl
// Front end of the streaming RS encoder. It takes one request (a line count),
// sends the block count to the output controller, and then passes the data
// lines straight through to the line encoder. The stream is cut into RS blocks
// of BLOCK_LINES lines, and the final short block is padded with zero lines.
// Optional feature macro: RS_ENCODE_IN_CTRL_STALL_CNT_EN. When it is defined,
// the block gains a saturating count of cycles in which the line encoder
// stalls a valid line.
module rs_encode_stream_in_ctrl #(
  parameter int DATA_W      = 256,
  parameter int BLOCK_LINES = 8,
  parameter int LINE_CNT_W  = 16,
  parameter int BLOCK_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_stream_encoder_req_val,
  input  logic [LINE_CNT_W-1:0]  src_stream_encoder_req_num_lines,
  output logic                   stream_encoder_src_req_rdy,
  input  logic                   src_stream_encoder_req_data_val,
  input  logic [DATA_W-1:0]      src_stream_encoder_req_data,
  output logic                   stream_encoder_src_req_data_rdy,
  output logic                   in_ctrl_out_ctrl_val,
  output logic [BLOCK_CNT_W-1:0] in_ctrl_out_ctrl_num_blocks,
  input  logic                   out_ctrl_in_ctrl_rdy,
  output logic                   in_encode_line_encode_val,
  output logic [DATA_W-1:0]      in_encode_line_encode_data,
  output logic                   in_encode_line_encode_pad,
  output logic                   in_encode_line_encode_last,
`ifdef RS_ENCODE_IN_CTRL_STALL_CNT_EN
  output logic [31:0]            in_ctrl_stall_cycles,
`endif
  input  logic                   line_encode_in_encode_rdy
);

  localparam int BLK_W = $clog2(BLOCK_LINES);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_META  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_PAD   = 2'd3;

  logic [1:0]             state_r;
  logic [LINE_CNT_W-1:0]  num_lines_r;
  logic [BLOCK_CNT_W-1:0] num_blocks_r;
  logic [BLK_W-1:0]       blk_line_r;
  logic [LINE_CNT_W-1:0]  lines_seen_r;

  logic                   req_rdy_s;
  logic                   meta_val_s;
  logic                   enc_val_s;
  logic [DATA_W-1:0]      enc_data_s;
  logic                   enc_pad_s;
  logic                   enc_last_s;
  logic                   src_data_rdy_s;
  logic                   blk_end_s;
  logic                   final_line_s;
  logic                   data_hs_s;

  // Compute ceil(n / BLOCK_LINES). The sum uses one extra bit, so the round-up
  // carry is kept and cannot overflow.
  function automatic logic [BLOCK_CNT_W-1:0] calc_num_blocks(input logic [LINE_CNT_W-1:0] n);
    logic [LINE_CNT_W:0] sum_v;
    sum_v = {1'b0, n} + (LINE_CNT_W+1)'(BLOCK_LINES - 1);
    return BLOCK_CNT_W'(sum_v >> BLK_W);
  endfunction

  assign blk_end_s    = (blk_line_r == BLK_W'(BLOCK_LINES - 1));
  assign final_line_s = (lines_seen_r == (num_lines_r - LINE_CNT_W'(1)));
  assign data_hs_s    = src_stream_encoder_req_data_val & line_encode_in_encode_rdy;

  // Decode the handshake and data-path outputs from the current state.
  always_comb begin
    req_rdy_s      = 1'b0;
    meta_val_s     = 1'b0;
    enc_val_s      = 1'b0;
    enc_data_s     = '0;
    enc_pad_s      = 1'b0;
    enc_last_s     = 1'b0;
    src_data_rdy_s = 1'b0;
    case (state_r)
      ST_READY: req_rdy_s = 1'b1;
      ST_META:  meta_val_s = 1'b1;
      ST_DATA: begin
        enc_val_s      = src_stream_encoder_req_data_val;
        enc_data_s     = src_stream_encoder_req_data;
        enc_last_s     = blk_end_s;
        src_data_rdy_s = line_encode_in_encode_rdy;
      end
      ST_PAD: begin
        enc_val_s  = 1'b1;
        enc_pad_s  = 1'b1;
        enc_last_s = blk_end_s;
      end
      default: req_rdy_s = 1'b0;
    endcase
  end

  assign stream_encoder_src_req_rdy      = req_rdy_s & ~rst;
  assign stream_encoder_src_req_data_rdy = src_data_rdy_s;
  assign in_ctrl_out_ctrl_val            = meta_val_s;
  assign in_ctrl_out_ctrl_num_blocks     = num_blocks_r;
  assign in_encode_line_encode_val       = enc_val_s;
  assign in_encode_line_encode_data      = enc_data_s;
  assign in_encode_line_encode_pad       = enc_pad_s;
  assign in_encode_line_encode_last      = enc_last_s;

  // Request state machine: it tracks the position inside the RS block and the
  // number of source lines consumed so far.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_READY;
      num_lines_r  <= '0;
      num_blocks_r <= '0;
      blk_line_r   <= '0;
      lines_seen_r <= '0;
    end else begin
      case (state_r)
        ST_READY: begin
          if (src_stream_encoder_req_val) begin
            num_lines_r  <= src_stream_encoder_req_num_lines;
            num_blocks_r <= calc_num_blocks(src_stream_encoder_req_num_lines);
            blk_line_r   <= '0;
            lines_seen_r <= '0;
            // A zero-line request is consumed and produces no output.
            if (src_stream_encoder_req_num_lines == LINE_CNT_W'(0)) begin
              state_r <= ST_READY;
            end else begin
              state_r <= ST_META;
            end
          end
        end
        ST_META: begin
          if (out_ctrl_in_ctrl_rdy) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_hs_s) begin
            blk_line_r   <= blk_line_r + BLK_W'(1);
            lines_seen_r <= lines_seen_r + LINE_CNT_W'(1);
            if (final_line_s) begin
              state_r <= blk_end_s ? ST_READY : ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (line_encode_in_encode_rdy) begin
            blk_line_r <= blk_line_r + BLK_W'(1);
            if (blk_end_s) begin
              state_r <= ST_READY;
            end
          end
        end
        default: state_r <= ST_READY;
      endcase
    end
  end

`ifdef RS_ENCODE_IN_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Count the cycles in which a valid line is stalled by the line encoder. The
  // count saturates at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (enc_val_s && !line_encode_in_encode_rdy &&
                 ((state_r == ST_DATA) || (state_r == ST_PAD)) &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign in_ctrl_stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_rs_encode_stream_in_ctrl.sv
// Self-checking bench for rs_encode_stream_in_ctrl. Expected metadata and
// lines are queued when a request is issued. A negedge monitor pops and
// compares them on every output handshake.
module tb_rs_encode_stream_in_ctrl;

  localparam int DW = 256;
  localparam int BL = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          pad;
    logic          last;
  } line_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_val = 1'b0;
  logic [15:0]   req_num = 16'd0;
  logic          req_rdy;
  logic          src_val = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_rdy;
  logic          meta_val;
  logic [15:0]   meta_blocks;
  logic          meta_rdy = 1'b0;
  logic          enc_val;
  logic [DW-1:0] enc_data;
  logic          enc_pad;
  logic          enc_last;
  logic          enc_rdy = 1'b1;
`ifdef RS_ENCODE_IN_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  int            rdy_mode = 0;
  int            stall_exp = 0;
  logic [15:0]   exp_meta_q[$];
  line_t         exp_line_q[$];
  logic [DW-1:0] lines_buf[$];

  rs_encode_stream_in_ctrl dut (
    .clk                              (clk),
    .rst                              (rst),
    .src_stream_encoder_req_val       (req_val),
    .src_stream_encoder_req_num_lines (req_num),
    .stream_encoder_src_req_rdy       (req_rdy),
    .src_stream_encoder_req_data_val  (src_val),
    .src_stream_encoder_req_data      (src_data),
    .stream_encoder_src_req_data_rdy  (src_rdy),
    .in_ctrl_out_ctrl_val             (meta_val),
    .in_ctrl_out_ctrl_num_blocks      (meta_blocks),
    .out_ctrl_in_ctrl_rdy             (meta_rdy),
    .in_encode_line_encode_val        (enc_val),
    .in_encode_line_encode_data       (enc_data),
    .in_encode_line_encode_pad        (enc_pad),
    .in_encode_line_encode_last       (enc_last),
`ifdef RS_ENCODE_IN_CTRL_STALL_CNT_EN
    .in_ctrl_stall_cycles             (stall_cycles),
`endif
    .line_encode_in_encode_rdy        (enc_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout", name);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: ceil(n/BL) blocks, then n data lines followed by zero
  // pad lines up to a full block. Every BL-th line is marked last.
  task automatic push_expect(input int n);
    int blocks;
    line_t l;
    blocks = (n + BL - 1) / BL;
    if (n > 0) exp_meta_q.push_back(16'(blocks));
    for (int i = 0; i < blocks * BL; i++) begin
      l.data = (i < n) ? lines_buf[i] : '0;
      l.pad  = (i >= n);
      l.last = ((i % BL) == BL - 1);
      exp_line_q.push_back(l);
    end
  endtask

  // Line-encoder ready pattern: 0 = always ready, 1 = toggling, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: enc_rdy = ~enc_rdy;
      2: enc_rdy = ($urandom_range(0, 2) != 0);
      default: enc_rdy = 1'b1;
    endcase
  end

  // Scoreboard monitor: on each output handshake, pop the expected item and
  // compare it with the DUT output.
  always @(negedge clk) begin
    line_t e;
    if (rst) begin
      stall_exp = 0;
    end else begin
      if (enc_val && !enc_rdy) stall_exp++;
      if (meta_val && meta_rdy) begin
        if (exp_meta_q.size() == 0) begin
          chk("unexpected_meta", 256'(1), 256'(0));
        end else begin
          chk("num_blocks", 256'(meta_blocks), 256'(exp_meta_q.pop_front()));
        end
      end
      if (enc_val && enc_rdy) begin
        if (exp_line_q.size() == 0) begin
          chk("unexpected_line", 256'(1), 256'(0));
        end else begin
          e = exp_line_q.pop_front();
          chk("line_data", enc_data, e.data);
          chk("line_pad", 256'(enc_pad), 256'(e.pad));
          chk("line_last", 256'(enc_last), 256'(e.last));
        end
      end
    end
  end

  task automatic wait_req_ack();
    bit ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_rdy) begin ok = 1; break; end
    end
    if (!ok) fail_timeout("req_handshake");
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  // Issue one request. meta_dly holds the metadata ready low for that many
  // cycles. gaps inserts random idle cycles on the source side.
  task automatic run_req(input int n, input int meta_dly, input bit gaps);
    bit ok;
    lines_buf.delete();
    for (int i = 0; i < n; i++) lines_buf.push_back(rand_line());
    push_expect(n);
    meta_rdy = 1'b0;
    req_val  = 1'b1;
    req_num  = 16'(n);
    wait_req_ack();
    if (n == 0) begin
      repeat (2) @(negedge clk);
      chk("zero_req_meta_val", 256'(meta_val), 256'(0));
      chk("zero_req_rdy", 256'(req_rdy), 256'(1));
      @(posedge clk); #1;
      return;
    end
    src_val  = 1'b1;
    src_data = lines_buf[0];
    for (int c = 0; c < meta_dly; c++) begin
      @(negedge clk);
      chk("meta_val_held", 256'(meta_val), 256'(1));
      chk("no_data_in_meta", 256'(src_rdy), 256'(0));
      @(posedge clk); #1;
    end
    meta_rdy = 1'b1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (meta_val) begin ok = 1; break; end
    end
    if (!ok) fail_timeout("meta_handshake");
    @(posedge clk); #1;
    meta_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        src_val = 1'b0;
        @(posedge clk); #1;
      end
      src_val  = 1'b1;
      src_data = lines_buf[i];
      ok = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (src_rdy) begin ok = 1; break; end
      end
      if (!ok) fail_timeout("data_handshake");
      @(posedge clk); #1;
    end
    // An extra line offered while padding or idle must never be accepted.
    src_data = rand_line();
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      if (exp_line_q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
      chk("excess_not_acked", 256'(src_rdy), 256'(0));
      @(posedge clk); #1;
    end
    if (!ok) fail_timeout("drain");
    src_val = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("req_rdy_gated_in_rst", 256'(req_rdy), 256'(0));
    exp_meta_q.delete();
    exp_line_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_enc_val", 256'(enc_val), 256'(0));
    chk("rst_meta_val", 256'(meta_val), 256'(0));
    chk("rst_req_rdy", 256'(req_rdy), 256'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("req_rdy_gated_in_rst", 256'(req_rdy), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_rdy", 256'(req_rdy), 256'(1));
    chk("reset_meta_val", 256'(meta_val), 256'(0));
    chk("reset_enc_val", 256'(enc_val), 256'(0));
    chk("reset_data_rdy", 256'(src_rdy), 256'(0));
    @(posedge clk); #1;

    rdy_mode = 0;
    run_req(16, 0, 1'b0);
    run_req(13, 0, 1'b0);
    run_req(1, 0, 1'b0);
    run_req(0, 0, 1'b0);
    run_req(4, 5, 1'b0);
    rdy_mode = 1;
    run_req(10, 1, 1'b0);

    // Reset in the middle of padding: 2 data lines, then 2 of 6 pads accepted.
    rdy_mode = 0;
    lines_buf.delete();
    lines_buf.push_back(rand_line());
    lines_buf.push_back(rand_line());
    push_expect(2);
    req_val = 1'b1;
    req_num = 16'd2;
    wait_req_ack();
    meta_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src_val  = 1'b1;
      src_data = lines_buf[i];
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (src_rdy) begin ok = 1; break; end
      end
      if (!ok) fail_timeout("rst_test_data");
      @(posedge clk); #1;
    end
    src_val  = 1'b0;
    meta_rdy = 1'b0;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (exp_line_q.size() <= 4) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_timeout("rst_test_pads");
    chk("pads_before_rst", 256'(exp_line_q.size()), 256'(4));
    rst = 1'b1;
    exp_meta_q.delete();
    exp_line_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_enc_val", 256'(enc_val), 256'(0));
    chk("rst_meta_val", 256'(meta_val), 256'(0));
    chk("rst_req_rdy", 256'(req_rdy), 256'(1));
    @(posedge clk); #1;
    run_req(8, 0, 1'b0);

    // Largest line count: checks the round-up carry. The reset then drops the request.
    exp_meta_q.push_back(16'd8192);
    req_val = 1'b1;
    req_num = 16'hFFFF;
    wait_req_ack();
    meta_rdy = 1'b1;
    @(posedge clk); #1;
    meta_rdy = 1'b0;
    chk("max_meta_popped", 256'(exp_meta_q.size()), 256'(0));
    pulse_reset();

    for (int r = 0; r < 12; r++) begin
      rdy_mode = $urandom_range(0, 2);
      run_req($urandom_range(0, 40), $urandom_range(0, 3), 1'b1);
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    chk("meta_q_empty", 256'(exp_meta_q.size()), 256'(0));
    chk("line_q_empty", 256'(exp_line_q.size()), 256'(0));
`ifdef RS_ENCODE_IN_CTRL_STALL_CNT_EN
    chk("stall_cycles", 256'(stall_cycles), 256'(stall_exp));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
